// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// The result is computed when the operation launches and is held in rHI/rLO.
// It is copied to HI/LO only when the fixed-latency countdown reaches zero.
module md_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MDM_Sel,
    input  logic        Req,
    output logic        Busy,
    output logic [31:0] MDOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned W         = 32;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned MUL_LAT   = 5;
    localparam int unsigned DIV_LAT   = 10;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       rhi_q, rhi_d;
    logic [W-1:0]       rlo_q, rlo_d;
    logic [W-1:0]       hi_q, hi_d;
    logic [W-1:0]       lo_q, lo_d;

    logic [2*W-1:0]     prod;
    logic [W-1:0]       a_mag, b_mag, q_mag, r_mag;
    logic [W-1:0]       res_hi, res_lo;
    logic               sgn;

    // Result datapath: product or quotient/remainder for the operation being launched.
    // Divide by zero returns the current HI/LO, so the completion commit leaves them unchanged.
    always_comb begin
        prod   = '0;
        sgn    = 1'b0;
        a_mag  = A;
        b_mag  = B;
        q_mag  = '0;
        r_mag  = '0;
        res_hi = hi_q;
        res_lo = lo_q;
        if (MDOp == OP_MULT) begin
            prod = {{W{A[W-1]}}, A} * {{W{B[W-1]}}, B};
        end else begin
            prod = {{W{1'b0}}, A} * {{W{1'b0}}, B};
        end
        sgn = (MDOp == OP_DIV);
        if (sgn && A[W-1]) a_mag = W'(-A);
        if (sgn && B[W-1]) b_mag = W'(-B);
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        if (MDOp == OP_MULT || MDOp == OP_MULTU) begin
            res_hi = prod[2*W-1:W];
            res_lo = prod[W-1:0];
        end else if (B != '0) begin
            res_lo = (sgn && (A[W-1] ^ B[W-1])) ? W'(-q_mag) : q_mag;
            res_hi = (sgn && A[W-1]) ? W'(-r_mag) : r_mag;
        end
    end

    // Next-state logic: launch, countdown/commit, and MTHI/MTLO writes while idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rhi_d   = rhi_q;
        rlo_d   = rlo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (!Req) begin
                    if (Start && !MDOp[2]) begin
                        state_d = RUN;
                        cnt_d   = MDOp[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                        rhi_d   = res_hi;
                        rlo_d   = res_lo;
                    end else if (!Start && MDOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (!Start && MDOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = rhi_q;
                    lo_d    = rlo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and architectural registers; reset clears everything, including an in-flight result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rhi_q   <= '0;
            rlo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rhi_q   <= rhi_d;
            rlo_q   <= rlo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy  = (state_q == RUN);
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = MDM_Sel ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: latency, results, MTHI/MTLO, flush, reset and collisions.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MDM_Sel;
    logic        Req;
    logic        Busy;
    logic [31:0] MDOut;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_cmp = 0;
    int n_err = 0;

    md_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .MDM_Sel (MDM_Sel),
        .Req     (Req),
        .Busy    (Busy),
        .MDOut   (MDOut),
        .HI      (HI),
        .LO      (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock step; inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch an operation and count the cycles Busy stays high (bounded at 40).
    // hi_last/lo_last are the HI/LO values seen in the last busy cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output logic [31:0] hi_last, output logic [31:0] lo_last);
        Start = 1'b1; MDOp = op; A = a; B = b;
        step();
        Start = 1'b0; MDOp = 3'b000;
        nbusy = 0; hi_last = HI; lo_last = LO;
        while (Busy && nbusy < 40) begin
            nbusy++;
            hi_last = HI; lo_last = LO;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Start = 1'b0; MDOp = 3'b000; A = '0; B = '0; MDM_Sel = 1'b0; Req = 1'b0;
        step(); step();
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
        n_cmp++; if (HI !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", HI); end
        n_cmp++; if (LO !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", LO); end
        n_cmp++; if (MDOut !== 32'h0) begin n_err++; $display("FAIL reset_mdout: got %h want 0", MDOut); end
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int n; logic [31:0] hl, ll;
        run_op(3'b000, 32'hFFFFFFFE, 32'h3, n, hl, ll);
        n_cmp++; if (n != 5) begin n_err++; $display("FAIL mult_busy: got %0d want 5", n); end
        n_cmp++; if (hl !== 32'h0 || ll !== 32'h0) begin n_err++; $display("FAIL mult_early: got %h/%h want 0/0", hl, ll); end
        n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
        n_cmp++; if (LO !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
        MDM_Sel = 1'b1; #1;
        n_cmp++; if (MDOut !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_mdout_lo: got %h want fffffffa", MDOut); end
        MDM_Sel = 1'b0; #1;
        n_cmp++; if (MDOut !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_mdout_hi: got %h want ffffffff", MDOut); end
    endtask

    task automatic test_multu();
        int n; logic [31:0] hl, ll;
        run_op(3'b001, 32'hFFFFFFFF, 32'h2, n, hl, ll);
        n_cmp++; if (n != 5) begin n_err++; $display("FAIL multu_busy: got %0d want 5", n); end
        n_cmp++; if (HI !== 32'h1) begin n_err++; $display("FAIL multu_hi: got %h want 00000001", HI); end
        n_cmp++; if (LO !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_lo: got %h want fffffffe", LO); end
    endtask

    task automatic test_div();
        int n; logic [31:0] hl, ll;
        run_op(3'b010, 32'hFFFFFFF9, 32'h2, n, hl, ll);
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL div_busy: got %0d want 10", n); end
        n_cmp++; if (hl !== 32'h1 || ll !== 32'hFFFFFFFE) begin n_err++; $display("FAIL div_early: got %h/%h want 00000001/fffffffe", hl, ll); end
        n_cmp++; if (LO !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_lo: got %h want fffffffd", LO); end
        n_cmp++; if (HI !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_hi: got %h want ffffffff", HI); end
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, n, hl, ll);
        n_cmp++; if (LO !== 32'h80000000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", LO); end
        n_cmp++; if (HI !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 0", HI); end
        run_op(3'b011, 32'hFFFFFFFF, 32'h10, n, hl, ll);
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL divu_busy: got %0d want 10", n); end
        n_cmp++; if (LO !== 32'h0FFFFFFF) begin n_err++; $display("FAIL divu_lo: got %h want 0fffffff", LO); end
        n_cmp++; if (HI !== 32'hF) begin n_err++; $display("FAIL divu_hi: got %h want 0000000f", HI); end
    endtask

    task automatic test_mt_div0();
        int n; logic [31:0] hl, ll;
        MDOp = 3'b100; A = 32'h11; step();
        n_cmp++; if (HI !== 32'h11 || Busy !== 1'b0) begin n_err++; $display("FAIL mthi: got %h busy %b want 00000011 busy 0", HI, Busy); end
        MDOp = 3'b101; A = 32'h22; step();
        MDOp = 3'b000;
        n_cmp++; if (LO !== 32'h22 || Busy !== 1'b0) begin n_err++; $display("FAIL mtlo: got %h busy %b want 00000022 busy 0", LO, Busy); end
        run_op(3'b011, 32'h1234, 32'h0, n, hl, ll);
        n_cmp++; if (n != 10) begin n_err++; $display("FAIL div0_busy: got %0d want 10", n); end
        n_cmp++; if (HI !== 32'h11 || LO !== 32'h22) begin n_err++; $display("FAIL div0_hold: got %h/%h want 00000011/00000022", HI, LO); end
    endtask

    task automatic test_flush();
        Req = 1'b1; Start = 1'b1; MDOp = 3'b000; A = 32'h5; B = 32'h5; step();
        n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL flush_start: got busy %b want 0", Busy); end
        Start = 1'b0; MDOp = 3'b100; A = 32'hDEAD; step();
        n_cmp++; if (HI !== 32'h11) begin n_err++; $display("FAIL flush_mthi: got %h want 00000011", HI); end
        Req = 1'b0; Start = 1'b1; MDOp = 3'b110; step();
        n_cmp++; if (Busy !== 1'b0 || HI !== 32'h11 || LO !== 32'h22) begin n_err++; $display("FAIL reserved_op: got busy %b %h/%h want 0 00000011/00000022", Busy, HI, LO); end
        MDOp = 3'b100; step();
        Start = 1'b0; MDOp = 3'b000;
        n_cmp++; if (Busy !== 1'b0 || HI !== 32'h11) begin n_err++; $display("FAIL start_mthi: got busy %b %h want 0 00000011", Busy, HI); end
    endtask

    task automatic test_reset_mid();
        Start = 1'b1; MDOp = 3'b011; A = 32'd100; B = 32'd7; step();
        Start = 1'b0; MDOp = 3'b000;
        step(); step(); step();
        #2 reset = 1'b0; #1;
        n_cmp++; if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0 || MDOut !== 32'h0) begin
            n_err++; $display("FAIL reset_mid: got busy %b %h/%h out %h want 0 0/0 0", Busy, HI, LO, MDOut); end
        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 12; i++) step();
        n_cmp++; if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            n_err++; $display("FAIL reset_nocommit: got busy %b %h/%h want 0 0/0", Busy, HI, LO); end
    endtask

    task automatic test_collision();
        int n;
        Start = 1'b1; MDOp = 3'b001; A = 32'd3; B = 32'd4; step();
        Start = 1'b0; MDOp = 3'b101; A = 32'h1234; step();
        MDOp = 3'b000;
        n = 0;
        while (Busy && n < 40) begin n++; step(); end
        n_cmp++; if (n != 4) begin n_err++; $display("FAIL coll_busy: got %0d want 4", n); end
        n_cmp++; if (LO !== 32'd12 || HI !== 32'h0) begin n_err++; $display("FAIL coll_result: got %h/%h want 00000000/0000000c", HI, LO); end
        MDOp = 3'b101; A = 32'h1234; step();
        MDOp = 3'b000;
        n_cmp++; if (LO !== 32'h1234 || Busy !== 1'b0) begin n_err++; $display("FAIL coll_mtlo: got %h busy %b want 00001234 busy 0", LO, Busy); end
    endtask

    task automatic test_back_to_back();
        int n; logic [31:0] hl, ll;
        run_op(3'b000, 32'd7, 32'hFFFFFFFF, n, hl, ll);
        n_cmp++; if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF9) begin n_err++; $display("FAIL b2b_mult: got %h/%h want ffffffff/fffffff9", HI, LO); end
        run_op(3'b011, 32'd100, 32'd7, n, hl, ll);
        n_cmp++; if (n != 10 || HI !== 32'd2 || LO !== 32'd14) begin n_err++; $display("FAIL b2b_divu: got n %0d %h/%h want 10 00000002/0000000e", n, HI, LO); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mt_div0();
        test_flush();
        test_reset_mid();
        test_collision();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
